// File: rtl/major_state_seq_pkg.sv
// Shared definitions for the major-state sequencer: state encoding,
// opcode constants, instruction word type and small decode helpers.
package major_state_seq_pkg;

    // Major state encoding: two high bits select the major cycle,
    // two low bits select the subcycle within it.
    typedef enum logic [3:0] {
        F0 = 4'h0, F1 = 4'h1, F2 = 4'h2, F3 = 4'h3,
        D0 = 4'h4, D1 = 4'h5, D2 = 4'h6, D3 = 4'h7,
        E0 = 4'h8, E1 = 4'h9, E2 = 4'hA, E3 = 4'hB,
        H0 = 4'hC, H1 = 4'hD, H2 = 4'hE, H3 = 4'hF
    } state_e;

    // Instruction word, bit 0 is the most significant bit.
    typedef logic [0:11] instr_t;
    typedef logic [2:0]  opcode_t;

    localparam opcode_t OP_AND = 3'd0;
    localparam opcode_t OP_TAD = 3'd1;
    localparam opcode_t OP_ISZ = 3'd2;
    localparam opcode_t OP_DCA = 3'd3;
    localparam opcode_t OP_JMS = 3'd4;
    localparam opcode_t OP_JMP = 3'd5;
    localparam opcode_t OP_IOT = 3'd6;
    localparam opcode_t OP_OPR = 3'd7;

    // Default HLT detection pattern (OPR group 2 with the HLT bit set).
    localparam instr_t HLT_MASK_DEF = 12'o7403;
    localparam instr_t HLT_VAL_DEF  = 12'o7402;

    function automatic opcode_t get_op(input instr_t ins);
        return ins[0:2];
    endfunction

    function automatic logic get_ib(input instr_t ins);
        return ins[3];
    endfunction

endpackage

// File: rtl/major_state_seq_if.sv
// Bus between the front panel / memory side and the major-state sequencer.
interface major_state_seq_if;
    import major_state_seq_pkg::*;

    instr_t     instruction;
    logic       cont;
    logic       sing_step;
    logic       halt_sw;
    logic [3:0] state;
    logic       run;
    logic       instr_done;

    // Driver side: supplies the instruction and panel controls.
    modport master (
        output instruction, cont, sing_step, halt_sw,
        input  state, run, instr_done
    );

    // Sequencer side.
    modport slave (
        input  instruction, cont, sing_step, halt_sw,
        output state, run, instr_done
    );
endinterface

// File: rtl/major_state_seq_instr_class.sv
// Combinational instruction classifier: decides which major cycles an
// instruction needs and whether it is a JMP or a HLT.
module major_state_seq_instr_class
    import major_state_seq_pkg::*;
#(
    parameter instr_t HLT_MASK = HLT_MASK_DEF,
    parameter instr_t HLT_VAL  = HLT_VAL_DEF
) (
    input  instr_t instruction_i,
    output logic   needs_defer_o,
    output logic   needs_exec_o,
    output logic   is_jmp_o,
    output logic   is_hlt_o
);

    opcode_t op;
    logic    ib;

    assign op = get_op(instruction_i);
    assign ib = get_ib(instruction_i);

    // Memory-reference instructions (AND..JMP) take a defer cycle when
    // indirect; only AND..JMS need an execute cycle. IOT/OPR ignore ib.
    always_comb begin
        needs_defer_o = (op <= OP_JMP) && ib;
        needs_exec_o  = (op <= OP_JMS);
        is_jmp_o      = (op == OP_JMP);
        is_hlt_o      = (op == OP_OPR) && ((instruction_i & HLT_MASK) == HLT_VAL);
    end

endmodule

// File: rtl/major_state_seq.sv
// Major-state sequencer: walks each instruction through Fetch, optional
// Defer and Execute subcycles, and idles in the Halt ring under panel control.
module major_state_seq
    import major_state_seq_pkg::*;
#(
    parameter instr_t HLT_MASK = HLT_MASK_DEF,
    parameter instr_t HLT_VAL  = HLT_VAL_DEF
) (
    input  logic               clk,
    input  logic               reset,
    major_state_seq_if.slave   bus
);

    state_e state_q;
    state_e state_d;
    state_e end_state;

    logic needs_defer;
    logic needs_exec;
    logic is_jmp;
    logic is_hlt;
    logic run_c;
    logic instr_done_c;

    major_state_seq_instr_class #(
        .HLT_MASK (HLT_MASK),
        .HLT_VAL  (HLT_VAL)
    ) u_instr_class (
        .instruction_i (bus.instruction),
        .needs_defer_o (needs_defer),
        .needs_exec_o  (needs_exec),
        .is_jmp_o      (is_jmp),
        .is_hlt_o      (is_hlt)
    );

    // Where to go once an instruction has finished its last subcycle.
    assign end_state = (bus.halt_sw || bus.sing_step) ? H0 : F0;

    // State register; active-low reset drops straight into the halt ring.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= H0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: step through subcycles, branch only at the x3 subcycles.
    always_comb begin
        state_d = state_e'(state_q + 4'd1);
        unique case (state_q)
            F3: begin
                if (needs_defer) begin
                    state_d = D0;
                end else if (needs_exec) begin
                    state_d = E0;
                end else if (is_hlt) begin
                    state_d = H0;
                end else begin
                    state_d = end_state;
                end
            end
            D3: state_d = is_jmp ? end_state : E0;
            E3: state_d = end_state;
            H3: state_d = (bus.cont && !bus.halt_sw) ? F0 : H0;
            default: ;
        endcase
    end

    // Outputs decoded from the current state and instruction.
    always_comb begin
        run_c        = (state_q[3:2] != 2'b11);
        instr_done_c = 1'b0;
        unique case (state_q)
            F3:      instr_done_c = !needs_defer && !needs_exec;
            D3:      instr_done_c = is_jmp;
            E3:      instr_done_c = 1'b1;
            default: instr_done_c = 1'b0;
        endcase
    end

    assign bus.state      = state_q;
    assign bus.run        = run_c;
    assign bus.instr_done = instr_done_c;

endmodule
